// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU types and constants: fetch FSM encoding, opcode
//               field position and default fetch-unit reset/step values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int          OPCODE_MSB   = 31;
  localparam int          OPCODE_LSB   = 26;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_PC_STEP  = 4;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program counter register with sequential-step and target load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_reg #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_seq,
  input  logic              load_target,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_seq
);

  localparam logic [ADDR_W-1:0] c_step = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] r_pc;

  // A target load always overrides the sequential step.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (load_target) begin
      r_pc <= target;
    end else if (load_seq) begin
      r_pc <= r_pc + c_step;
    end
  end

  assign pc          = r_pc;
  assign pc_next_seq = r_pc + c_step;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Multicycle fetch stage: PC, memory read, IR latch, redirects.
//               Optional IFU_PERF_CNT_EN adds perf_fetched / perf_stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int                PC_STEP  = DEF_PC_STEP
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              ir_accept,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
`endif
  output logic [ADDR_W-1:0] pc_next_seq
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [31:0]       r_ir;
  logic              r_ir_valid;
  logic              r_squash;
  logic [ADDR_W-1:0] r_pend_target;

  logic              w_load_seq;
  logic              w_load_target;
  logic [ADDR_W-1:0] w_target;
  logic              w_ir_load;
  logic              w_ir_clr;
  logic              w_squash_set;
  logic              w_squash_clr;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clock       (clock),
    .reset       (reset),
    .load_seq    (w_load_seq),
    .load_target (w_load_target),
    .target      (w_target),
    .pc          (pc),
    .pc_next_seq (pc_next_seq)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_load_seq    = 1'b0;
    w_load_target = 1'b0;
    w_target      = redirect_target;
    w_ir_load     = 1'b0;
    w_ir_clr      = 1'b0;
    w_squash_set  = 1'b0;
    w_squash_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        if (mem_ready) begin
          // A redirect pending or arriving now makes the returned word stale.
          if (r_squash || redirect_valid) begin
            w_load_target = 1'b1;
            w_squash_clr  = 1'b1;
            if (!redirect_valid) begin
              w_target = r_pend_target;
            end
          end else begin
            w_ir_load    = 1'b1;
            w_state_next = HOLD;
          end
        end else if (redirect_valid) begin
          w_squash_set = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_load_target = 1'b1;
          w_ir_clr      = 1'b1;
          w_state_next  = FETCH;
        end else if (ir_accept) begin
          w_load_seq    = 1'b1;
          w_ir_clr      = 1'b1;
          w_state_next  = FETCH;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ir          <= 32'h0;
      r_ir_valid    <= 1'b0;
      r_squash      <= 1'b0;
      r_pend_target <= '0;
    end else begin
      if (w_ir_load) begin
        r_ir       <= mem_rdata;
        r_ir_valid <= 1'b1;
      end else if (w_ir_clr) begin
        r_ir_valid <= 1'b0;
      end
      if (w_squash_set) begin
        r_squash      <= 1'b1;
        r_pend_target <= redirect_target;
      end else if (w_squash_clr) begin
        r_squash      <= 1'b0;
      end
    end
  end

  assign mem_req  = (r_state == FETCH);
  assign mem_addr = pc;
  assign ir       = r_ir;
  assign ir_valid = r_ir_valid;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_fetched <= 32'h0;
      r_perf_stall   <= 32'h0;
    end else begin
      if (w_ir_load) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if ((r_state == FETCH) && !mem_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

`default_nettype wire
